// File: rtl/seven_segment_scan_pkg.sv
// Shared constants and the hex-to-segment decode table for the scanned display driver.
package seven_segment_scan_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    // Bit positions inside the {G,F,E,D,C,B,A} segment vector.
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Active-high segment pattern for one hex digit.
    function automatic logic [SEG_W-1:0] hex_to_seg7(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_segment_scan_if.sv
// User-side load bus plus board-side segment/anode pins of the scanned display.
interface seven_segment_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
) ();

    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blank;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_tick;

    modport master (
        output load, value, dp_in, blank,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  load, value, dp_in, blank,
        output seg, dp, an, frame_tick
    );

endinterface

// File: rtl/seven_segment_scan_hex_to_seg.sv
// Combinational nibble to active-high {G..A} segment decode; polarity is applied by the caller.
module hex_to_seg
    import seven_segment_scan_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [SEG_W-1:0] seg_c_o
);

    // Table lookup only.
    always_comb begin
        seg_c_o = hex_to_seg7(nib_i);
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed N-digit hex display driver with frame-synchronous double buffering.
module seven_segment_scan
    import seven_segment_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned BLANK_CYC      = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seven_segment_scan_if.slave  bus
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_OFF   = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  ftick_q, ftick_d;

    logic                  cnt_wrap;
    logic                  boundary;
    logic [NIB_W-1:0]      cur_nib;
    logic [SEG_W-1:0]      cur_seg_hi;
    logic [NUM_DIGITS-1:0] cur_onehot;

    // Prescaler and digit index; boundary marks the last cycle of the last digit slot.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_MAX);
        boundary = cnt_wrap && (idx_q == IDX_MAX);
        cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Pending/active buffers: loads land in pending, swap only at a frame boundary,
    // and a load coinciding with the boundary bypasses straight to active.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_vld_d   = pend_vld_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        if (bus.load) begin
            pend_val_d   = bus.value;
            pend_dp_d    = bus.dp_in;
            pend_blank_d = bus.blank;
            pend_vld_d   = 1'b1;
        end
        if (boundary) begin
            if (bus.load) begin
                act_val_d   = bus.value;
                act_dp_d    = bus.dp_in;
                act_blank_d = bus.blank;
                pend_vld_d  = 1'b0;
            end else if (pend_vld_q) begin
                act_val_d   = pend_val_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
                pend_vld_d  = 1'b0;
            end
        end
    end

    assign cur_nib = act_val_q[NIB_W*32'(idx_q) +: NIB_W];

    hex_to_seg u_hex_to_seg (
        .nib_i   (cur_nib),
        .seg_c_o (cur_seg_hi)
    );

    // Next pin values: dark during the blank window, otherwise the selected digit.
    always_comb begin
        an_d       = AN_OFF;
        seg_d      = SEG_OFF;
        dp_d       = DP_OFF;
        ftick_d    = boundary;
        cur_onehot = NUM_DIGITS'(1) << idx_q;
        if (cnt_q >= BLANK_END) begin
            an_d = AN_ACTIVE_LOW ? ~cur_onehot : cur_onehot;
            if (!act_blank_q[idx_q]) begin
                seg_d = SEG_ACTIVE_LOW ? ~cur_seg_hi : cur_seg_hi;
                dp_d  = act_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_vld_q   <= 1'b0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            ftick_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_vld_q   <= pend_vld_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            ftick_q      <= ftick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = ftick_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan: 4 digits, 4-cycle slots, 1 blank cycle, active-low pins.
module tb_seven_segment_scan;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seven_segment_scan_if #(.NUM_DIGITS(4)) bus ();

    seven_segment_scan #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .BLANK_CYC      (1),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  blank;
        logic [27:0] exp_seg;   // {d3,d2,d1,d0} pin levels
        logic [3:0]  exp_dp;    // pin levels per digit
    } vec_t;

    vec_t       vecs [5];
    logic [6:0] hex_tab [16];
    logic [3:0] prev_an = 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pulse(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        bus.value = v;
        bus.dp_in = d;
        bus.blank = b;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic wait_frame();
        for (int n = 0; n < 64 && bus.frame_tick !== 1'b1; n++) tick();
        check("frame_tick_wait", 32'(bus.frame_tick), 32'd1);
    endtask

    // Observe one full frame after a frame_tick; optionally inject up to two loads
    // sampled on the edges that produce samples load_at and load_at+1.
    task automatic frame_check(input string name, input logic [27:0] es, input logic [3:0] ed,
                               input int load_at, input int n_loads,
                               input logic [15:0] lv1, input logic [15:0] lv2);
        logic [3:0]  oh;
        logic [11:0] exp_pins;
        int slot, pos;
        wait_frame();
        for (int j = 1; j <= 16; j++) begin
            bus.load = 1'b0;
            if (n_loads >= 1 && j == load_at) begin
                bus.value = lv1; bus.dp_in = 4'h0; bus.blank = 4'h0; bus.load = 1'b1;
            end else if (n_loads >= 2 && j == load_at + 1) begin
                bus.value = lv2; bus.dp_in = 4'h0; bus.blank = 4'h0; bus.load = 1'b1;
            end
            tick();
            slot = (j - 1) / 4;
            pos  = (j - 1) % 4;
            if (pos == 0) begin
                exp_pins = {4'hF, 7'h7F, 1'b1};
            end else begin
                oh       = 4'b0001 << slot;
                exp_pins = {~oh, es[slot*7 +: 7], ed[slot]};
            end
            check($sformatf("%s pins s%0d", name, j), 32'({bus.an, bus.seg, bus.dp}), 32'(exp_pins));
            check($sformatf("%s tick s%0d", name, j), 32'(bus.frame_tick), (j == 16) ? 32'd1 : 32'd0);
        end
        bus.load = 1'b0;
    endtask

    // Continuous pin-safety monitor: at most one anode, no direct digit-to-digit switch.
    always @(negedge clk) begin
        checks++;
        if ($countones(~bus.an) > 1) begin
            failures++;
            $display("FAIL an_onehot actual=%h required=at_most_one_low", bus.an);
        end
        if (bus.an !== prev_an) begin
            checks++;
            if (prev_an !== 4'hF && bus.an !== 4'hF) begin
                failures++;
                $display("FAIL an_switch actual=%h->%h required=via_F", prev_an, bus.an);
            end
        end
        prev_an = bus.an;
    end

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0] = '{16'h1234, 4'h0, 4'h0,      {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vecs[1] = '{16'h5555, 4'h0, 4'h0,      {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF};
        vecs[2] = '{16'hFFFF, 4'h0, 4'h0,      {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'hF};
        vecs[3] = '{16'h89AB, 4'b0001, 4'b0100, {7'h00, 7'h7F, 7'h08, 7'h03}, 4'b1110};
        vecs[4] = '{16'h0F0F, 4'b1010, 4'h0,   {7'h40, 7'h0E, 7'h40, 7'h0E}, 4'b0101};

        rst_n     = 1'b0;
        bus.load  = 1'b0;
        bus.value = '0;
        bus.dp_in = '0;
        bus.blank = '0;

        // Reset state held.
        repeat (3) tick();
        check("rst_an",   32'(bus.an),         32'h0F);
        check("rst_seg",  32'(bus.seg),        32'h7F);
        check("rst_dp",   32'(bus.dp),         32'd1);
        check("rst_tick", 32'(bus.frame_tick), 32'd0);
        rst_n = 1'b1;

        // Table: load, then the next full frame must show it.
        for (int i = 0; i < 5; i++) begin
            load_pulse(vecs[i].value, vecs[i].dp_in, vecs[i].blank);
            frame_check($sformatf("vec%0d", i), vecs[i].exp_seg, vecs[i].exp_dp, 0, 0, 16'h0, 16'h0);
        end

        // Tear-free: two mid-frame loads leave the live frame alone; last load wins next frame.
        load_pulse(16'h1234, 4'h0, 4'h0);
        frame_check("tear_cur",   vecs[0].exp_seg, 4'hF, 6, 2, 16'hAAAA, 16'h5555);
        frame_check("tear_next",  vecs[1].exp_seg, 4'hF, 0, 0, 16'h0, 16'h0);
        frame_check("tear_next2", vecs[1].exp_seg, 4'hF, 0, 0, 16'h0, 16'h0);

        // Load in the boundary cycle goes straight live and stays.
        frame_check("coll_cur",   vecs[1].exp_seg, 4'hF, 16, 1, 16'hFFFF, 16'h0);
        frame_check("coll_next",  vecs[2].exp_seg, 4'hF, 0, 0, 16'h0, 16'h0);
        frame_check("coll_next2", vecs[2].exp_seg, 4'hF, 0, 0, 16'h0, 16'h0);

        // Every hex code on digit 0, other digits showing 0.
        for (int n = 0; n < 16; n++) begin
            load_pulse(16'(n), 4'h0, 4'h0);
            frame_check($sformatf("hex%0h", n), {7'h40, 7'h40, 7'h40, ~hex_tab[n]}, 4'hF,
                        0, 0, 16'h0, 16'h0);
        end

        // Reset mid-scan while digit 0 is lit: dark at once, data lost afterwards.
        wait_frame();
        repeat (3) tick();
        check("pre_rst_an", 32'(bus.an), 32'h0E);
        rst_n = 1'b0;
        #1;
        check("mid_rst_an",   32'(bus.an),         32'h0F);
        check("mid_rst_seg",  32'(bus.seg),        32'h7F);
        check("mid_rst_dp",   32'(bus.dp),         32'd1);
        check("mid_rst_tick", 32'(bus.frame_tick), 32'd0);
        tick();
        check("mid_rst_hold", 32'({bus.an, bus.seg, bus.dp}), 32'({4'hF, 7'h7F, 1'b1}));
        rst_n = 1'b1;
        frame_check("post_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 0, 0, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
